// File: rtl/rv32_encoder.sv
// RV32I/RV32M instruction encoder: assembles a machine word from decoded
// fields, validates op/func/imm, and queues {word, error} in a small FIFO.
module rv32_encoder #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       op,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rd,
  input  logic [9:0]       func,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [31:0] Nop     = 32'h00000013;

  logic [6:0]  f7;
  logic [2:0]  f3;
  logic        op_ok, func_ok, imm_ok;
  logic [31:0] word;
  logic [1:0]  enc_err;
  logic [31:0] enc_instr;

  // Immediate range checks: sign bits above the field must all agree.
  logic imm12_ok, shamt_ok, b_ok, j_ok, u_ok;
  assign f7       = func[9:3];
  assign f3       = func[2:0];
  assign imm12_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign shamt_ok = (imm[31:5] == '0);
  assign b_ok     = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
  assign j_ok     = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];
  assign u_ok     = (imm[31:20] == '0);

  logic [31:0] mem_q [DEPTH];
  logic [1:0]  err_mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [CNT_W-1:0] enc_cnt_q, err_cnt_q;
  logic push, pop;

  assign in_ready  = !rst && (count_q < CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_err   = out_valid ? err_mem_q[rd_ptr_q] : '0;
  assign enc_cnt   = enc_cnt_q;
  assign err_cnt   = err_cnt_q;

  // Field layout and legality per opcode; errors collapse to a NOP word.
  always_comb begin
    op_ok   = 1'b1;
    func_ok = 1'b1;
    imm_ok  = 1'b1;
    word    = '0;
    case (op)
      OpR: begin
        func_ok = (f7 == 7'b0000000) || (f7 == 7'b0000001) ||
                  ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
        word    = {f7, rs2, rs1, f3, rd, op};
      end
      OpImm: begin
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
          func_ok = (f7 == 7'b0000000) || ((f3 == 3'b101) && (f7 == 7'b0100000));
          imm_ok  = shamt_ok;
          word    = {f7, imm[4:0], rs1, f3, rd, op};
        end else begin
          func_ok = (f7 == 7'b0000000);
          imm_ok  = imm12_ok;
          word    = {imm[11:0], rs1, f3, rd, op};
        end
      end
      OpLoad: begin
        func_ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        imm_ok  = imm12_ok;
        word    = {imm[11:0], rs1, f3, rd, op};
      end
      OpJalr: begin
        func_ok = (f3 == 3'b000);
        imm_ok  = imm12_ok;
        word    = {imm[11:0], rs1, f3, rd, op};
      end
      OpStore: begin
        func_ok = (f3 <= 3'b010);
        imm_ok  = imm12_ok;
        word    = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      end
      OpBranch: begin
        func_ok = (f3 != 3'b010) && (f3 != 3'b011);
        imm_ok  = b_ok;
        word    = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      end
      OpLui, OpAuipc: begin
        imm_ok = u_ok;
        word   = {imm[19:0], rd, op};
      end
      OpJal: begin
        imm_ok = j_ok;
        word   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      end
      default: op_ok = 1'b0;
    endcase

    if (!op_ok)        enc_err = 2'd1;
    else if (!func_ok) enc_err = 2'd2;
    else if (!imm_ok)  enc_err = 2'd3;
    else               enc_err = 2'd0;
    enc_instr = (enc_err == 2'd0) ? word : Nop;
  end

  // FIFO storage; push is already blocked during reset through in_ready.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]     <= enc_instr;
      err_mem_q[wr_ptr_q] <= enc_err;
    end
  end

  // FIFO pointers, occupancy and statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (!push && pop) count_q <= count_q - CntW'(1);
      if (push) enc_cnt_q <= enc_cnt_q + CNT_W'(1);
      if (push && (enc_err != 2'd0)) err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

endmodule
